// File: rtl/shadow_stack_unit_pkg.sv
// Shared types and defaults for the shadow-stack engine: op encodings,
// FSM states and the default on-chip buffer depth.
package shadow_stack_unit_pkg;

    typedef enum logic [2:0] {
        SS_NOP    = 3'd0,
        SS_PUSH   = 3'd1,
        SS_POPCHK = 3'd2,
        SS_RR     = 3'd3,
        SS_INC    = 3'd4,
        SS_WR     = 3'd5
    } ss_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPILL = 3'd1,
        ST_FILL  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_RESP  = 3'd4
    } ss_state_e;

    localparam int unsigned SS_DEPTH = 4;
    localparam int unsigned SS_IMM_W = 8;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned ss_count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shadow_stack_unit_if.sv
// Issue-stage request/response channel, architectural SSP and the
// spill/fill memory port of the shadow-stack engine, bundled together.
// The master modport is the engine itself; slave is its environment.
interface shadow_stack_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            xbcfie_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      req_op_i;
    logic [XLEN-1:0] req_data_i;
    logic [7:0]      req_imm_i;
    logic            resp_valid_o;
    logic [XLEN-1:0] resp_result_o;
    logic            resp_fault_o;
    logic [XLEN-1:0] ssp_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport master (
        input  xbcfie_i, req_valid_i, req_op_i, req_data_i, req_imm_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_result_o, resp_fault_o, ssp_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output xbcfie_i, req_valid_i, req_op_i, req_data_i, req_imm_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_result_o, resp_fault_o, ssp_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/shadow_stack_unit_ss_entry_buffer.sv
// On-chip stack of the most recent return addresses. Entry 0 is the top;
// the bottom valid entry sits at index count-1. A push may coincide with
// a pop-bottom, which is how a spill makes room for the incoming entry.
module ss_entry_buffer
    import shadow_stack_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = SS_DEPTH,
    localparam int unsigned CW   = ss_count_width(DEPTH),
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    input  logic            drop,
    input  logic [CW-1:0]   drop_n,
    input  logic            pop_bottom,
    output logic [XLEN-1:0] top,
    output logic [XLEN-1:0] bottom,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    logic [XLEN-1:0] entries_q [DEPTH];
    logic [XLEN-1:0] entries_d [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    // Next contents: push shifts everything down, pop and drop shift up,
    // pop-bottom only shrinks the valid window.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (push) begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                entries_d[i] = entries_q[i-1];
            end
            entries_d[0] = push_data;
            if (!pop_bottom) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                entries_d[i] = entries_q[i+1];
            end
            count_d = count_q - CW'(1);
        end else if (drop) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i + int'(drop_n) < int'(DEPTH)) begin
                    entries_d[i] = entries_q[AW'(i + int'(drop_n))];
                end
            end
            count_d = count_q - drop_n;
        end else if (pop_bottom) begin
            count_d = count_q - CW'(1);
        end
    end

    // Entry storage and occupancy register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    assign top    = entries_q[0];
    assign bottom = entries_q[AW'(count_q - CW'(1))];
    assign count  = count_q;
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/shadow_stack_unit.sv
// Shadow-stack engine for backward-edge CFI. Owns the architectural SSP,
// keeps the top DEPTH return addresses on chip, and spills/fills/flushes
// through a single-outstanding req/gnt/rvalid memory port.
module shadow_stack_unit
    import shadow_stack_unit_pkg::*;
#(
    parameter int unsigned     XLEN      = 64,
    parameter int unsigned     DEPTH     = SS_DEPTH,
    parameter logic [XLEN-1:0] RESET_SSP = '0
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    shadow_stack_unit_if.master bus
);

    localparam logic [XLEN-1:0] BYTES = XLEN'(XLEN / 8);
    localparam int unsigned     CW    = ss_count_width(DEPTH);

    ss_state_e       state_q;
    ss_state_e       state_d;
    logic [XLEN-1:0] ssp_q;
    logic [XLEN-1:0] ssp_d;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] result_d;
    logic            fault_q;
    logic            fault_d;
    logic            wait_q;
    logic            wait_d;
    logic            fill_done;
    logic            accept;

    logic            buf_push;
    logic [XLEN-1:0] buf_push_data;
    logic            buf_pop;
    logic            buf_drop;
    logic [CW-1:0]   buf_drop_n;
    logic            buf_pop_bottom;
    logic [XLEN-1:0] buf_top;
    logic [XLEN-1:0] buf_bottom;
    logic [CW-1:0]   buf_count;
    logic            buf_full;
    logic            buf_empty;
    logic [XLEN-1:0] bottom_addr;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;

    ss_entry_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (buf_push),
        .push_data  (buf_push_data),
        .pop        (buf_pop),
        .drop       (buf_drop),
        .drop_n     (buf_drop_n),
        .pop_bottom (buf_pop_bottom),
        .top        (buf_top),
        .bottom     (buf_bottom),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    assign accept      = bus.req_valid_i && bus.req_ready_o;
    // The bottom buffered entry mirrors the highest buffered address.
    assign bottom_addr = ssp_q + (XLEN'(buf_count) - XLEN'(1)) * BYTES;

    // Next-state, SSP arithmetic, buffer control and memory port drive.
    always_comb begin
        state_d        = state_q;
        ssp_d          = ssp_q;
        data_d         = data_q;
        result_d       = result_q;
        fault_d        = fault_q;
        wait_d         = wait_q;
        fill_done      = 1'b0;
        buf_push       = 1'b0;
        buf_push_data  = data_q;
        buf_pop        = 1'b0;
        buf_drop       = 1'b0;
        buf_drop_n     = '0;
        buf_pop_bottom = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_RESP;
                    data_d   = bus.req_data_i;
                    result_d = '0;
                    fault_d  = 1'b0;
                    wait_d   = 1'b0;
                    if (bus.xbcfie_i) begin
                        case (ss_op_e'(bus.req_op_i))
                            SS_PUSH: begin
                                if (buf_full) begin
                                    state_d = ST_SPILL;
                                end else begin
                                    buf_push      = 1'b1;
                                    buf_push_data = bus.req_data_i;
                                    ssp_d         = ssp_q - BYTES;
                                end
                            end
                            SS_POPCHK: begin
                                if (buf_empty) begin
                                    state_d = ST_FILL;
                                end else begin
                                    fault_d = (buf_top != bus.req_data_i);
                                    buf_pop = 1'b1;
                                    ssp_d   = ssp_q + BYTES;
                                end
                            end
                            SS_RR: begin
                                result_d = ssp_q;
                            end
                            SS_INC: begin
                                ssp_d    = ssp_q + XLEN'(bus.req_imm_i) * BYTES;
                                buf_drop = 1'b1;
                                if (XLEN'(bus.req_imm_i) > XLEN'(buf_count)) begin
                                    buf_drop_n = buf_count;
                                end else begin
                                    buf_drop_n = CW'(bus.req_imm_i);
                                end
                            end
                            SS_WR: begin
                                if (buf_empty) begin
                                    ssp_d = bus.req_data_i;
                                end else begin
                                    state_d = ST_FLUSH;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end

            ST_SPILL: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = bottom_addr;
                mem_wdata = buf_bottom;
                if (bus.mem_gnt_i) begin
                    buf_pop_bottom = 1'b1;
                    buf_push       = 1'b1;
                    ssp_d          = ssp_q - BYTES;
                    state_d        = ST_RESP;
                end
            end

            ST_FILL: begin
                if (!wait_q) begin
                    mem_req  = 1'b1;
                    mem_addr = ssp_q;
                    if (bus.mem_gnt_i) begin
                        if (bus.mem_rvalid_i) begin
                            fill_done = 1'b1;
                        end else begin
                            wait_d = 1'b1;
                        end
                    end
                end else if (bus.mem_rvalid_i) begin
                    fill_done = 1'b1;
                end
                if (fill_done) begin
                    fault_d = (bus.mem_rdata_i != data_q);
                    ssp_d   = ssp_q + BYTES;
                    wait_d  = 1'b0;
                    state_d = ST_RESP;
                end
            end

            ST_FLUSH: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = bottom_addr;
                mem_wdata = buf_bottom;
                if (bus.mem_gnt_i) begin
                    buf_pop_bottom = 1'b1;
                    if (buf_count == CW'(1)) begin
                        ssp_d   = data_q;
                        state_d = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // SSP, latched operand and pending response registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ssp_q    <= RESET_SSP;
            data_q   <= '0;
            result_q <= '0;
            fault_q  <= 1'b0;
            wait_q   <= 1'b0;
        end else begin
            ssp_q    <= ssp_d;
            data_q   <= data_d;
            result_q <= result_d;
            fault_q  <= fault_d;
            wait_q   <= wait_d;
        end
    end

    assign bus.req_ready_o   = rst_ni && (state_q == ST_IDLE);
    assign bus.resp_valid_o  = (state_q == ST_RESP);
    assign bus.resp_result_o = (state_q == ST_RESP) ? result_q : '0;
    assign bus.resp_fault_o  = (state_q == ST_RESP) && fault_q;
    assign bus.ssp_o         = ssp_q;
    assign bus.mem_req_o     = mem_req;
    assign bus.mem_we_o      = mem_we;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_wdata_o   = mem_wdata;

endmodule
